lpm_rom_arbiter: RTL and testbench

Round-robin read arbiter that lets up to `num_req` independent requesters share one `lpm_rom` instance configured with `lpm_address_control = "REGISTERED"` and `lpm_outdata = "REGISTERED"`, both ROM clocks tied to `clock`. It grants at most one read per cycle and drives the ROM address. It carries the winning requester's index through the ROM's 2-cycle pipeline and returns data with a per-requester valid strobe. It sits between the client blocks (table lookups, microcode fetch) and the ROM.

---
 rtl/lpm_rom_arbiter.sv | 117 +++++++++++
 tb/tb_lpm_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lpm_rom_arbiter.sv
// Round-robin read arbiter in front of a 2-cycle registered lpm_rom; tracks winner index to returns.
// Optional out-of-range checking is enabled by defining LPM_ROM_ARB_BOUND_CHECK_EN.
module lpm_rom_arbiter #(
  parameter int unsigned lpm_width    = 8,
  parameter int unsigned lpm_widthad  = 8,
  parameter int unsigned lpm_numwords = 1 << lpm_widthad,
  parameter int unsigned num_req      = 4
) (
  input  logic                           clock,
  input  logic                           aclr_n,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*lpm_widthad-1:0] addr,
  output logic [num_req-1:0]             gnt,
  output logic [num_req-1:0]             rvalid,
  output logic [lpm_width-1:0]           rdata,
  output logic                           rerr,
  output logic [lpm_widthad-1:0]         rom_address,
  output logic                           rom_memenab,
  input  logic [lpm_width-1:0]           rom_q
);

  localparam int unsigned PtrW = $clog2(num_req);

  logic [PtrW-1:0]        ptr_q;
  logic [PtrW-1:0]        win_idx;
  logic                   win_found;
  logic [lpm_widthad-1:0] sel_addr;
  logic [lpm_widthad-1:0] addr_q;
  logic                   grant_err;

  logic                   s1_valid_q, s2_valid_q;
  logic [PtrW-1:0]        s1_idx_q, s2_idx_q;
  logic                   s1_err_q, s2_err_q;

  // Scan req starting at ptr_q, wrapping modulo num_req; first hit wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(num_req); k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(num_req)) cand = cand - int'(num_req);
      for (int j = 0; j < int'(num_req); j++) begin
        if (!win_found && (j == cand) && req[j]) begin
          win_found = 1'b1;
          win_idx   = PtrW'(j);
        end
      end
    end
  end

  always_comb begin
    gnt      = '0;
    sel_addr = '0;
    for (int j = 0; j < int'(num_req); j++) begin
      gnt[j] = win_found && (win_idx == PtrW'(j));
      if (gnt[j]) sel_addr = addr[j*lpm_widthad +: lpm_widthad];
    end
  end

`ifdef LPM_ROM_ARB_BOUND_CHECK_EN
  assign grant_err = win_found && (64'(sel_addr) >= 64'(lpm_numwords));
`else
  assign grant_err = 1'b0;
`endif

  // Out-of-range grants still launch, but the ROM sees address 0.
  always_comb begin
    if (!win_found)     rom_address = addr_q;
    else if (grant_err) rom_address = '0;
    else                rom_address = sel_addr;
  end

  assign rom_memenab = 1'b1;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr_q      <= '0;
      addr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      if (win_found) begin
        addr_q <= rom_address;
        if (win_idx == PtrW'(num_req - 1)) ptr_q <= '0;
        else                                ptr_q <= win_idx + PtrW'(1);
      end
      s1_valid_q <= win_found;
      s1_idx_q   <= win_idx;
      s1_err_q   <= grant_err;
      s2_valid_q <= s1_valid_q;
      s2_idx_q   <= s1_idx_q;
      s2_err_q   <= s1_err_q;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int j = 0; j < int'(num_req); j++) begin
      rvalid[j] = s2_valid_q && (s2_idx_q == PtrW'(j));
    end
  end

  assign rdata = (s2_valid_q && !s2_err_q) ? rom_q : '0;

`ifdef LPM_ROM_ARB_BOUND_CHECK_EN
  assign rerr = s2_valid_q && s2_err_q;
`else
  assign rerr = 1'b0;
`endif

endmodule

// File: tb/tb_lpm_rom_arbiter.sv
// Randomized bench for lpm_rom_arbiter with a behavioural ROM and a due-cycle return scoreboard.
module tb_lpm_rom_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int DW   = 8;
  localparam int NUMW = 200;
`ifdef LPM_ROM_ARB_BOUND_CHECK_EN
  localparam bit BoundCheck = 1'b1;
`else
  localparam bit BoundCheck = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           aclr_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] addr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [DW-1:0]  rdata;
  logic           rerr;
  logic [W-1:0]   rom_address;
  logic           rom_memenab;
  logic [DW-1:0]  rom_q;

  lpm_rom_arbiter #(
    .lpm_width   (DW),
    .lpm_widthad (W),
    .lpm_numwords(NUMW),
    .num_req     (N)
  ) dut (
    .clock      (clock),
    .aclr_n     (aclr_n),
    .req        (req),
    .addr       (addr),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rerr       (rerr),
    .rom_address(rom_address),
    .rom_memenab(rom_memenab),
    .rom_q      (rom_q)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rom_fn(input int a);
    return DW'((a * 29 + 7) ^ (a >> 3) ^ 8'hA5);
  endfunction

  // ROM with registered address and registered output.
  logic [W-1:0] rom_a_q;
  always @(posedge clock) begin
    rom_a_q <= rom_address;
    rom_q   <= rom_fn(int'(rom_a_q));
  end

  typedef struct {
    int due;
    int idx;
    int a;
    bit err;
  } ret_t;

  ret_t q[$];
  int   m_ptr;
  int   m_last;
  int   cyc;
  int   n_cmp;
  int   n_mis;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check combinational and returning outputs, update model.
  task automatic do_cycle(input logic [N-1:0] r, input logic [N*W-1:0] a);
    int   w;
    int   a_w;
    bit   e;
    int   exp_addr;
    ret_t ent;
    req  = r;
    addr = a;
    #2;
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    a_w = 0;
    e   = 1'b0;
    if (w >= 0) begin
      a_w      = int'(a[w*W +: W]);
      e        = BoundCheck && (a_w >= NUMW);
      exp_addr = e ? 0 : a_w;
    end else begin
      exp_addr = m_last;
    end
    check_val("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
    check_val("rom_address", 32'(rom_address), 32'(exp_addr));
    check_val("rom_memenab", 32'(rom_memenab), 32'd1);
    if (q.size() > 0 && q[0].due == cyc) begin
      ent = q.pop_front();
      check_val("rvalid", 32'(rvalid), 32'd1 << ent.idx);
      check_val("rdata", 32'(rdata), ent.err ? 32'd0 : 32'(rom_fn(ent.a)));
      check_val("rerr", 32'(rerr), 32'(ent.err));
    end else begin
      check_val("rvalid_idle", 32'(rvalid), 32'd0);
      check_val("rdata_idle", 32'(rdata), 32'd0);
      check_val("rerr_idle", 32'(rerr), 32'd0);
    end
    if (w >= 0) begin
      q.push_back('{due: cyc + 2, idx: w, a: a_w, err: e});
      m_ptr  = (w + 1) % N;
      m_last = exp_addr;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Reset held across n edges; in-flight entries are discarded.
  task automatic do_reset(input int n);
    req    = '0;
    aclr_n = 1'b0;
    #2;
    q.delete();
    m_ptr  = 0;
    m_last = 0;
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_rdata", 32'(rdata), 32'd0);
    check_val("rst_rom_address", 32'(rom_address), 32'd0);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      check_val("rst_hold_rvalid", 32'(rvalid), 32'd0);
    end
    aclr_n = 1'b1;
  endtask

  function automatic logic [N*W-1:0] mk(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic idle(input int n);
    repeat (n) do_cycle('0, '0);
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    cyc    = 0;
    m_ptr  = 0;
    m_last = 0;
    aclr_n = 1'b0;
    req    = '0;
    addr   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_gnt", 32'(gnt), 32'd0);
    check_val("reset_rvalid", 32'(rvalid), 32'd0);
    check_val("reset_rdata", 32'(rdata), 32'd0);
    check_val("reset_rerr", 32'(rerr), 32'd0);
    check_val("reset_rom_address", 32'(rom_address), 32'd0);
    check_val("reset_memenab", 32'(rom_memenab), 32'd1);
    aclr_n = 1'b1;

    // Single request, address 5.
    do_cycle(4'b0001, mk(5, 0, 0, 0));
    idle(3);

    // All requesters high from reset: strict rotation.
    do_reset(1);
    for (int i = 0; i < 8; i++) do_cycle(4'b1111, mk(16 + i, 32 + i, 48 + i, 64 + i));
    idle(3);

    // Wrap-around: last grant to 1, then requesters 0 and 1.
    do_cycle(4'b0010, mk(0, 9, 0, 0));
    do_cycle(4'b0011, mk(10, 11, 0, 0));
    do_cycle(4'b0011, mk(12, 13, 0, 0));
    idle(3);

    // Reset with two grants in flight.
    do_cycle(4'b0001, mk(20, 0, 0, 0));
    do_cycle(4'b0010, mk(0, 21, 0, 0));
    do_reset(1);
    idle(3);
    do_cycle(4'b1111, mk(1, 2, 3, 4));
    idle(3);

    // Out-of-range address.
    do_cycle(4'b0100, mk(0, 0, 8'hC8, 0));
    idle(3);
    do_cycle(4'b1000, mk(0, 0, 0, 8'hFF));
    idle(3);

    // One client streaming every cycle.
    for (int i = 0; i < 5; i++) do_cycle(4'b1000, mk(0, 0, 0, i));
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 2));
      do_cycle(N'($urandom), (N*W)'({$urandom, $urandom}));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
